// File: rtl/accum_warp_retire_collector_pkg.sv
// Shared widths, retire record payload and helpers for the accumulate retire collector.
package accum_warp_retire_collector_pkg;

  localparam int unsigned N_ICFG   = 4;
  localparam int unsigned MAX_WARP = 4;
  localparam int unsigned WID_BW   = $clog2(MAX_WARP);
  localparam int unsigned NCFG_BW  = $clog2(N_ICFG + 1);
  localparam int unsigned CNT_BW   = $clog2(N_ICFG + 1);

  typedef struct packed {
    logic [WID_BW-1:0] warpid;
    logic [N_ICFG-1:0] mask;
    logic [CNT_BW-1:0] nbeat;
    logic              islast;
  } retire_rec_t;

  function automatic logic [CNT_BW-1:0] popcount(input logic [N_ICFG-1:0] m);
    logic [CNT_BW-1:0] s;
    s = '0;
    for (int k = 0; k < int'(N_ICFG); k++) s = s + CNT_BW'(m[k]);
    return s;
  endfunction

endpackage

// File: rtl/accum_warp_retire_collector_if.sv
// Index-beat input stream and retire-record output stream of the collector.
interface accum_warp_retire_collector_if;
  import accum_warp_retire_collector_pkg::*;

  logic               src_rdy;
  logic               src_ack;
  logic [NCFG_BW-1:0] i_id;
  logic [WID_BW-1:0]  i_warpid;
  logic               i_retire;
  logic               i_islast;

  logic               dst_rdy;
  logic               dst_ack;
  logic [WID_BW-1:0]  o_warpid;
  logic [N_ICFG-1:0]  o_mask;
  logic [CNT_BW-1:0]  o_cnt;
  logic [CNT_BW-1:0]  o_nbeat;
  logic               o_islast;

  modport master (
    output src_rdy, i_id, i_warpid, i_retire, i_islast, dst_ack,
    input  src_ack, dst_rdy, o_warpid, o_mask, o_cnt, o_nbeat, o_islast
  );

  modport slave (
    input  src_rdy, i_id, i_warpid, i_retire, i_islast, dst_ack,
    output src_ack, dst_rdy, o_warpid, o_mask, o_cnt, o_nbeat, o_islast
  );
endinterface

// File: rtl/accum_warp_retire_collector_retire_record_fifo.sv
// Record FIFO with two in-order write ports and one read port; storage clears on reset.
module retire_record_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         rec_t = logic,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned PW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we0,
  input  rec_t          wd0,
  input  logic          we1,
  input  rec_t          wd1,
  input  logic          re,
  output rec_t          rd,
  output logic          empty,
  output logic [PW-1:0] occ
);

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  assign occ   = wr_ptr_q - rd_ptr_q;
  assign empty = (occ == '0);
  assign rd    = mem_q[rd_ptr_q[AW-1:0]];

  // Port 0 always lands in the lower slot when both ports write.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (we0) begin
      mem_d[wr_ptr_d[AW-1:0]] = wd0;
      wr_ptr_d                = wr_ptr_d + PW'(1);
    end
    if (we1) begin
      mem_d[wr_ptr_d[AW-1:0]] = wd1;
      wr_ptr_d                = wr_ptr_d + PW'(1);
    end
    rd_ptr_d = rd_ptr_q + PW'(re && !empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/accum_warp_retire_collector.sv
// Folds per-warp retire beats into retire records and queues them for the retire logic.
module accum_warp_retire_collector
  import accum_warp_retire_collector_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                          i_clk,
  input logic                          i_rst_n,
  accum_warp_retire_collector_if.slave bus
);

  localparam int unsigned OCC_BW = $clog2(DEPTH) + 1;

  logic [OCC_BW-1:0] occ;
  logic              empty;
  retire_rec_t       head, wd0, wd1;
  logic              we0, we1, acc;

  logic              hold_v_q, hold_v_d;
  logic [WID_BW-1:0] hold_wid_q, hold_wid_d;
  logic [N_ICFG-1:0] hold_mask_q, hold_mask_d;
  logic [CNT_BW-1:0] hold_nbeat_q, hold_nbeat_d;

  logic [N_ICFG-1:0] beat_bit, base_mask, mrg_mask;
  logic [CNT_BW-1:0] base_nb, mrg_nb;
  logic              new_warp, fresh, id_ok, sat;

  // Two free slots are required so a warp change plus block end always fits.
  always_comb begin
    acc       = bus.src_rdy && i_rst_n && (occ <= OCC_BW'(DEPTH - 2));
    id_ok     = bus.i_id < NCFG_BW'(N_ICFG);
    beat_bit  = id_ok ? (N_ICFG'(bus.i_retire) << bus.i_id) : '0;
    new_warp  = hold_v_q && (bus.i_warpid != hold_wid_q);
    fresh     = new_warp || !hold_v_q;
    base_mask = fresh ? '0 : hold_mask_q;
    base_nb   = fresh ? '0 : hold_nbeat_q;
    sat       = (base_nb == CNT_BW'(N_ICFG));
    mrg_mask  = base_mask | beat_bit;
    mrg_nb    = sat ? base_nb : base_nb + CNT_BW'(1);

    hold_v_d     = hold_v_q;
    hold_wid_d   = hold_wid_q;
    hold_mask_d  = hold_mask_q;
    hold_nbeat_d = hold_nbeat_q;
    we0          = 1'b0;
    we1          = 1'b0;
    wd0 = '{warpid: hold_wid_q, mask: hold_mask_q, nbeat: hold_nbeat_q, islast: 1'b0};
    wd1 = '{warpid: bus.i_warpid, mask: mrg_mask, nbeat: mrg_nb, islast: 1'b1};

    if (acc) begin
      we0          = new_warp;
      we1          = bus.i_islast;
      hold_v_d     = !bus.i_islast;
      hold_wid_d   = bus.i_warpid;
      hold_mask_d  = mrg_mask;
      hold_nbeat_d = mrg_nb;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_v_q     <= 1'b0;
      hold_wid_q   <= '0;
      hold_mask_q  <= '0;
      hold_nbeat_q <= '0;
    end else begin
      hold_v_q     <= hold_v_d;
      hold_wid_q   <= hold_wid_d;
      hold_mask_q  <= hold_mask_d;
      hold_nbeat_q <= hold_nbeat_d;
    end
  end

  // Out-of-range ids and beat-count overflow indicate a broken upstream looper.
  always @(posedge i_clk) begin
    if (i_rst_n && acc) begin
      assert (id_ok);
      assert (!sat);
    end
  end

  retire_record_fifo #(
    .DEPTH (DEPTH),
    .rec_t (retire_rec_t)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .we0   (we0),
    .wd0   (wd0),
    .we1   (we1),
    .wd1   (wd1),
    .re    (bus.dst_ack),
    .rd    (head),
    .empty (empty),
    .occ   (occ)
  );

  assign bus.src_ack  = acc;
  assign bus.dst_rdy  = !empty;
  assign bus.o_warpid = head.warpid;
  assign bus.o_mask   = head.mask;
  assign bus.o_cnt    = popcount(head.mask);
  assign bus.o_nbeat  = head.nbeat;
  assign bus.o_islast = head.islast;

endmodule

// File: tb/tb_accum_warp_retire_collector.sv
// Directed and random checks of the retire collector against hand-computed records.
module tb_accum_warp_retire_collector;
  import accum_warp_retire_collector_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  accum_warp_retire_collector_if bus ();

  accum_warp_retire_collector #(.DEPTH(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rec(input int w, input int m, input int c, input int nb, input int l);
    return {19'd0, 2'(w), 4'(m), 3'(c), 3'(nb), 1'(l)};
  endfunction

  function automatic logic [31:0] head();
    return {19'd0, bus.o_warpid, bus.o_mask, bus.o_cnt, bus.o_nbeat, bus.o_islast};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int id, input int wid, input int ret, input int last);
    bus.i_id     = 3'(id);
    bus.i_warpid = 2'(wid);
    bus.i_retire = 1'(ret);
    bus.i_islast = 1'(last);
  endtask

  task automatic send(input int id, input int wid, input int ret, input int last);
    int n;
    n = 0;
    set_beat(id, wid, ret, last);
    bus.src_rdy = 1'b1;
    #1;
    while (!bus.src_ack && n < 20) begin
      tick();
      #1;
      n++;
    end
    if (!bus.src_ack) check("send_timeout", 32'(bus.src_ack), 32'd1);
    tick();
    bus.src_rdy = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [31:0] exp);
    check({tag, "_rdy"}, 32'(bus.dst_rdy), 32'd1);
    check(tag, head(), exp);
    bus.dst_ack = 1'b1;
    tick();
    bus.dst_ack = 1'b0;
  endtask

  // Random-phase model state.
  logic [31:0] exq[$];
  logic        mv;
  int          mw, mm, mn;
  logic        have;
  int          b_id, b_wid, b_ret, b_last;
  int          gen_cnt, cur_wid;
  logic        cur_valid;
  int          beats, cycles;
  logic [31:0] exp_rec;

  task automatic gen_beat(input logic force_last);
    if (!(cur_valid && gen_cnt < 4 && $urandom_range(0, 2) != 0)) begin
      if (cur_valid) b_wid = (cur_wid + int'($urandom_range(1, 3))) % 4;
      else           b_wid = int'($urandom_range(0, 3));
      gen_cnt = 0;
    end else begin
      b_wid = cur_wid;
    end
    b_id   = int'($urandom_range(0, 3));
    b_ret  = int'($urandom_range(0, 1));
    b_last = (force_last || $urandom_range(0, 7) == 0) ? 1 : 0;
    gen_cnt++;
    cur_valid = (b_last == 0);
    cur_wid   = b_wid;
    have      = 1'b1;
  endtask

  task automatic model_accept();
    if (mv && b_wid != mw) exq.push_back(rec(mw, mm, $countones(4'(mm)), mn, 0));
    if (!mv || b_wid != mw) begin
      mm = 0;
      mn = 0;
    end
    mm = mm | (b_ret << b_id);
    mn = mn + 1;
    if (b_last != 0) begin
      exq.push_back(rec(b_wid, mm, $countones(4'(mm)), mn, 1));
      mv = 1'b0;
    end else begin
      mv = 1'b1;
      mw = b_wid;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    bus.src_rdy = 1'b1;
    bus.dst_ack = 1'b0;
    set_beat(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_head", head(), 32'd0);
    check("rst_dst_rdy", 32'(bus.dst_rdy), 32'd0);
    check("rst_src_ack", 32'(bus.src_ack), 32'd0);
    bus.src_rdy = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // Basic grouping
    send(0, 0, 1, 0);
    send(1, 0, 0, 0);
    send(2, 0, 1, 0);
    send(0, 1, 1, 0);
    send(1, 1, 1, 1);
    pop("grp0", rec(0, 4'b0101, 2, 3, 0));
    pop("grp1", rec(1, 4'b0011, 2, 2, 1));
    check("grp_empty", 32'(bus.dst_rdy), 32'd0);

    // Warp change and block end on one beat
    send(0, 0, 1, 0);
    check("dbl_none", 32'(bus.dst_rdy), 32'd0);
    send(0, 1, 0, 1);
    check("dbl_lat", 32'(bus.dst_rdy), 32'd1);
    pop("dbl0", rec(0, 4'b0001, 1, 1, 0));
    pop("dbl1", rec(1, 4'b0000, 0, 1, 1));
    check("dbl_empty", 32'(bus.dst_rdy), 32'd0);

    // Backpressure and pre-pop free count
    send(0, 0, 1, 0);
    send(0, 1, 1, 0);
    send(0, 2, 1, 0);
    send(0, 3, 1, 0);
    set_beat(1, 0, 1, 1);
    bus.src_rdy = 1'b1;
    #1;
    check("bp_full", 32'(bus.src_ack), 32'd0);
    tick();
    check("bp_full2", 32'(bus.src_ack), 32'd0);
    bus.dst_ack = 1'b1;
    #1;
    check("bp_poppre", 32'(bus.src_ack), 32'd0);
    check("bp_pophead", head(), rec(0, 4'b0001, 1, 1, 0));
    tick();
    bus.dst_ack = 1'b0;
    #1;
    check("bp_resume", 32'(bus.src_ack), 32'd1);
    tick();
    bus.src_rdy = 1'b0;
    pop("bp1", rec(1, 4'b0001, 1, 1, 0));
    pop("bp2", rec(2, 4'b0001, 1, 1, 0));
    pop("bp3", rec(3, 4'b0001, 1, 1, 0));
    pop("bp4", rec(0, 4'b0010, 1, 1, 1));
    check("bp_empty", 32'(bus.dst_rdy), 32'd0);

    // Asynchronous reset mid-warp
    send(2, 0, 1, 0);
    send(0, 1, 1, 0);
    send(1, 1, 1, 0);
    check("rst_pre", head(), rec(0, 4'b0100, 1, 1, 0));
    set_beat(2, 1, 1, 0);
    bus.src_rdy = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_head", head(), 32'd0);
    check("arst_dst_rdy", 32'(bus.dst_rdy), 32'd0);
    check("arst_src_ack", 32'(bus.src_ack), 32'd0);
    bus.src_rdy = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    send(3, 2, 1, 1);
    pop("arst_lone", rec(2, 4'b1000, 1, 1, 1));
    check("arst_empty", 32'(bus.dst_rdy), 32'd0);

    // Random stream against the model
    mv = 1'b0; mw = 0; mm = 0; mn = 0;
    have = 1'b0; gen_cnt = 0; cur_wid = 0; cur_valid = 1'b0;
    beats = 0; cycles = 0;
    while ((beats < 10000 || mv) && cycles < 60000) begin
      if (!have) gen_beat(beats >= 10000);
      set_beat(b_id, b_wid, b_ret, b_last);
      bus.src_rdy = ($urandom_range(0, 3) != 0);
      bus.dst_ack = 1'($urandom_range(0, 1));
      #1;
      if (bus.dst_rdy && bus.dst_ack) begin
        exp_rec = (exq.size() > 0) ? exq.pop_front() : 32'hDEAD_BEEF;
        check("rnd_rec", head(), exp_rec);
      end
      if (bus.src_ack) begin
        model_accept();
        have = 1'b0;
        beats++;
      end
      tick();
      cycles++;
    end
    check("rnd_beats_done", 32'(beats >= 10000 && !mv), 32'd1);
    bus.src_rdy = 1'b0;
    bus.dst_ack = 1'b1;
    cycles = 0;
    while (exq.size() > 0 && cycles < 50) begin
      #1;
      if (bus.dst_rdy) begin
        exp_rec = exq.pop_front();
        check("rnd_drain", head(), exp_rec);
      end
      tick();
      cycles++;
    end
    bus.dst_ack = 1'b0;
    #1;
    check("rnd_left", 32'(exq.size()), 32'd0);
    check("rnd_no_extra", 32'(bus.dst_rdy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
